bit_flip: RTL and testbench



---
 rtl/bit_flip.sv | 56 +++++
 tb/tb_bit_flip.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bit_flip.sv
// rtl/bit_flip.sv - registered bit-reversal of the low n_bits of an index, for FFT sample reordering
module bit_flip #(
    parameter int INDEX = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [INDEX-1:0]             in,
    input  logic [$clog2(INDEX+1)-1:0]   n_bits,
    output logic [INDEX-1:0]             out,
    output logic                         out_valid
);

    localparam int LW = $clog2(INDEX+1);

    logic [LW-1:0]    len;
    logic [INDEX-1:0] rev_d;
    logic [INDEX-1:0] out_q;
    logic             valid_q;

    // Zero or out-of-range length selects the full width.
    always_comb begin
        len = n_bits;
        if (n_bits == '0 || n_bits > LW'(INDEX)) begin
            len = LW'(INDEX);
        end
    end

    // One candidate source per length: each output bit is a mux over the INDEX lengths.
    always_comb begin
        rev_d = '0;
        for (int l = 1; l <= INDEX; l++) begin
            if (len == LW'(l)) begin
                for (int i = 0; i < l; i++) begin
                    rev_d[i] = in[l-1-i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q <= rev_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_bit_flip.sv
// tb/tb_bit_flip.sv - directed self-checking bench for bit_flip
module tb_bit_flip;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        in_valid;
    logic [15:0] din;
    logic [4:0]  n_bits;
    logic [15:0] dout;
    logic        out_valid;

    int n_checks;
    int n_fail;
    int seen [0:65535];

    bit_flip #(.INDEX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .n_bits    (n_bits),
        .out       (dout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: shift bits out LSB-first into a new word.
    function automatic logic [15:0] ref_rev(input logic [15:0] x, input int n);
        logic [15:0] r;
        int l;
        l = (n == 0 || n > 16) ? 16 : n;
        r = '0;
        for (int i = 0; i < l; i++) begin
            r = {r[14:0], x[i]};
        end
        return r;
    endfunction

    task automatic step(input string tag, input logic [15:0] x, input logic [4:0] n, input logic [15:0] exp);
        in_valid = 1'b1;
        din      = x;
        n_bits   = n;
        @(posedge clk);
        #1;
        check({tag, "_out"}, {16'h0, dout}, {16'h0, exp});
        check({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
    endtask

    initial begin
        logic [15:0] exp3 [0:7];
        int once;
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b1;
        din      = 16'hA5C3;
        n_bits   = 5'd16;
        for (int i = 0; i < 65536; i++) seen[i] = 0;

        #1 rst = 1'b1;
        #2;
        check("rst_out_noclk", {16'h0, dout}, 32'h0);
        check("rst_vld_noclk", {31'h0, out_valid}, 32'h0);

        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_hold", {16'h0, dout}, 32'h0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out", {16'h0, dout}, 32'h0);
        check("idle_vld", {31'h0, out_valid}, 32'h0);

        step("full_0000", 16'h0000, 5'd16, 16'h0000);
        step("full_ff00", 16'hFF00, 5'd16, 16'h00FF);
        step("full_0001", 16'h0001, 5'd16, 16'h8000);
        step("full_1234", 16'h1234, 5'd16, 16'h2C48);

        exp3[0] = 16'd0; exp3[1] = 16'd4; exp3[2] = 16'd2; exp3[3] = 16'd6;
        exp3[4] = 16'd1; exp3[5] = 16'd5; exp3[6] = 16'd3; exp3[7] = 16'd7;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("n3_%0d", i), 16'(i), 5'd3, exp3[i]);
        end
        step("n3_upper", 16'hFFF9, 5'd3, 16'h0004);
        step("n0_ff00", 16'hFF00, 5'd0, 16'h00FF);
        step("n17_ff00", 16'hFF00, 5'd17, 16'h00FF);
        step("n1_0001", 16'h0001, 5'd1, 16'h0001);
        step("n4_0001", 16'h0001, 5'd4, 16'h0008);
        step("n8_00f0", 16'hABF0, 5'd8, 16'h000F);

        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1;
            din      = 16'(i);
            n_bits   = 5'd16;
            @(posedge clk);
            #1;
            check("stream_vld", {31'h0, out_valid}, 32'h1);
            check("stream_out", {16'h0, dout}, {16'h0, ref_rev(16'(i), 16)});
            seen[dout] = seen[dout] + 1;
        end
        in_valid = 1'b0;
        din      = 16'h1357;
        @(posedge clk);
        #1;
        check("gap_vld", {31'h0, out_valid}, 32'h0);
        check("gap_hold", {16'h0, dout}, 32'h0000FFFF);
        once = 0;
        for (int i = 0; i < 65536; i++) begin
            if (seen[i] == 1) once++;
        end
        check("stream_unique", once, 65536);

        step("burst_a", 16'h0003, 5'd16, 16'hC000);
        in_valid = 1'b1;
        din      = 16'h00F0;
        n_bits   = 5'd16;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", {16'h0, dout}, 32'h0);
        check("midrst_vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_hold_out", {16'h0, dout}, 32'h0);
        check("midrst_hold_vld", {31'h0, out_valid}, 32'h0);
        rst = 1'b0;
        step("post_rst", 16'h1234, 5'd16, 16'h2C48);
        step("post_rst_n3", 16'h0006, 5'd3, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
